sqrt_scheduler: RTL and testbench
=================================

# sqrt_scheduler

Shares one iterative odd-increment square-root datapath among N requesters. Arbitrates pending requests, sequences the datapath through load/iterate/finish, and returns the integer square root with the winner's index. Sits between the requesting front-end logic (switch/button capture, display drivers) and the square-root arithmetic.

## Interface
- N, 4: number of requesters (2..8)
- WIDTH, 8: operand width, even; result width is WIDTH/2
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req  in  N  level request per requester; held until that requester's done pulse
- operand  in  N*WIDTH  requester i's operand at bits [i*WIDTH +: WIDTH]; stable while req[i] high
- grant  out  N  one-hot, high for the granted requester from LOAD through DONE
- busy  out  1  high in every state except IDLE
- done  out  N  one-cycle pulse on the granted requester's bit when result is valid
- result  out  WIDTH/2  floor(sqrt(operand)), valid while any done bit high, held until next DONE
- result_id  out  clog2(N)  index of requester that owns result

## Operation
- Reset: state IDLE, grant=0, busy=0, done=0, result=0, result_id=0, round-robin pointer=0, internal square/delta/operand=0.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE: if any req bit high, pick winner, capture its operand and index, set grant -> LOAD; else stay.
- LOAD: square=1, delta=3 -> ITER.
- ITER: if square > captured operand -> DONE, register result=(delta>>1)-1; else square+=delta, delta+=2, stay.
- DONE: done[id]=1, grant held, pointer=id+1 mod N -> IDLE.
- Arbitration: round-robin; search starts at pointer, wraps at N-1 -> 0.
- Widths: square WIDTH+1 bits (reaches 2^WIDTH for max operand), delta WIDTH/2+2 bits; no overflow for any operand.
- req[i] dropped mid-operation: computation completes, done[i] still pulses; no abort.
- Requester must deassert req[i] the cycle after done[i] or it is eligible again (lowest priority under round-robin).
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, no done pulse.
- Operand change while granted: ignored (captured copy used).

## Timing
- Grant edge: edge at which IDLE samples a request; grant visible after it.
- ITER add cycles = r = floor(sqrt(operand)); one extra ITER cycle for final compare.
- done visible r+3 cycles after grant edge (LOAD 1, ITER r+1, then DONE).
- Back-to-back: next grant edge is the edge leaving DONE+1 (one IDLE cycle between jobs); busy low for exactly one cycle between jobs.
- Operand 0: done 3 cycles after grant, result 0. Operand 255 (WIDTH=8): done 18 cycles after grant, result 15.

## Configuration
- SQRT_SCHED_FIXED_PRIORITY_EN defined: fixed priority, lowest index with req high always wins; pointer not maintained.
- Undefined (default): round-robin as above.

## Structure
- Shared package sqrt_pkg: state enum (IDLE, LOAD, ITER, DONE), default WIDTH/N constants.
- Sub-module sqrt_datapath: square/delta/operand registers, compare flag, result computation; controlled by load/step signals from scheduler FSM. Arbiter and FSM stay in sqrt_scheduler.

## Test plan
- Reset mid-ITER (req[0], operand 200, reset at cycle 8) -> all outputs 0, state IDLE, no done pulse.
- Single request req[2], operand 0, then 1, 4, 255 -> result 0,1,2,15; result_id 2; done at 3,4,5,18 cycles after grant.
- Exhaustive sweep req[0], operands 0..255 -> result equals floor(sqrt(x)) for all.
- All four req high, operands 16,25,36,49, held until own done -> grants in order 0,1,2,3; results 4,5,6,7; one idle cycle between jobs.
- Round-robin fairness: req[0] and req[1] permanently high -> grants alternate 0,1,0,1; with SQRT_SCHED_FIXED_PRIORITY_EN -> grant always 0.
- req[3] dropped and operand changed to 0 after grant (original 100) -> done[3] still pulses, result 10.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root scheduler slice: FSM state
// encoding and default sizing for the requester count and operand width.
package sqrt_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/sqrt_datapath.sv
// Iterative odd-increment square-root datapath. The scheduler captures an
// operand, loads the iteration seed, then steps until the running square
// exceeds the operand; the root is recovered from the odd increment.
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               capture,
  input  logic [WIDTH-1:0]   operand_in,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  output logic               sq_gt,
  output logic [WIDTH/2-1:0] result
);

  localparam int RW = WIDTH / 2;
  localparam int SW = WIDTH + 1;
  localparam int DW = WIDTH / 2 + 2;

  logic [WIDTH-1:0] op_q;
  logic [SW-1:0]    square;
  logic [DW-1:0]    delta;

  // Square holds (k+1)^2 and delta holds 2k+3, so the first square above the
  // operand leaves k = (delta>>1)-1 as the integer root.
  assign sq_gt = square > {1'b0, op_q};

  // Operand copy, running square/increment, and the registered result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      square <= '0;
      delta  <= '0;
      result <= '0;
    end else begin
      if (capture) begin
        op_q <= operand_in;
      end
      if (load) begin
        square <= SW'(1);
        delta  <= DW'(3);
      end else if (step) begin
        square <= square + SW'(delta);
        delta  <= delta + DW'(2);
      end
      if (finish) begin
        result <= RW'((delta >> 1) - DW'(1));
      end
    end
  end

endmodule

// File: rtl/sqrt_scheduler.sv
// Shares one square-root datapath among N requesters. Round-robin by
// default; defining SQRT_SCHED_FIXED_PRIORITY_EN switches to fixed priority
// where the lowest requesting index always wins.
module sqrt_scheduler
  import sqrt_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   operand,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic [N-1:0]         done,
  output logic [WIDTH/2-1:0]   result,
  output logic [$clog2(N)-1:0] result_id
);

  localparam int ID_W = $clog2(N);

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] result_id_q;
  logic [ID_W-1:0] winner;
  logic            any_req;
  logic            capture;
  logic            load;
  logic            step;
  logic            finish;
  logic            sq_gt;
  logic [WIDTH-1:0] sel_operand;

  assign sel_operand = operand[int'(winner)*WIDTH +: WIDTH];
  assign result_id   = result_id_q;

`ifdef SQRT_SCHED_FIXED_PRIORITY_EN
  // Fixed priority: scanning downward leaves the lowest requesting index.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner  = ID_W'(i);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;

  // Round-robin: first requester found scanning upward from the pointer.
  always_comb begin
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any_req && req[idx]) begin
        winner  = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Pointer moves just past the requester that was served.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (state == DONE) begin
      ptr <= (id_q == ID_W'(N - 1)) ? '0 : id_q + ID_W'(1);
    end
  end
`endif

  // State register plus the owner index of the job in flight and of the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      id_q        <= '0;
      result_id_q <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        id_q <= winner;
      end
      if (finish) begin
        result_id_q <= id_q;
      end
    end
  end

  // Sequencing of arbitration, load, iteration and completion.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          capture    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load       = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        if (sq_gt) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant/busy span the whole job; done marks only the completion cycle.
  always_comb begin
    grant = '0;
    done  = '0;
    busy  = (state != IDLE);
    if (state != IDLE) begin
      grant[id_q] = 1'b1;
    end
    if (state == DONE) begin
      done[id_q] = 1'b1;
    end
  end

  sqrt_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock      (clock),
    .reset      (reset),
    .capture    (capture),
    .operand_in (sel_operand),
    .load       (load),
    .step       (step),
    .finish     (finish),
    .sq_gt      (sq_gt),
    .result     (result)
  );

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Self-checking bench for sqrt_scheduler (N=4, WIDTH=8): vector table,
// exhaustive and random single-requester jobs against an arithmetic root,
// plus multi-requester, drop and reset-abort sequences.
module tb_sqrt_scheduler;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int RW    = WIDTH / 2;
  localparam int IDW   = $clog2(N);

  logic               clock = 1'b0;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] operand;
  logic [N-1:0]       grant;
  logic               busy;
  logic [N-1:0]       done;
  logic [RW-1:0]      result;
  logic [IDW-1:0]     result_id;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int id;
    int op;
    int exp_res;
    int exp_lat;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  sqrt_scheduler #(.N(N), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .operand   (operand),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_id (result_id)
  );

  // Reference: largest r with r*r <= x.
  function automatic int ref_sqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    operand = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Raise one request in IDLE, wait for done (bounded), drop it, then step
  // into the following IDLE cycle. Latency counts cycles after the grant edge.
  task automatic apply_stimulus(input int id, input int op, output int res, output int rid,
                                output int lat, output int held, output int done_bits);
    lat       = -1;
    res       = -1;
    rid       = -1;
    held      = -1;
    done_bits = 0;
    operand[id*WIDTH +: WIDTH] = WIDTH'(op);
    req[id] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done != '0) begin
        lat       = c;
        res       = int'(result);
        rid       = int'(result_id);
        done_bits = int'(done);
        break;
      end
    end
    req[id] = 1'b0;
    @(negedge clock);
    held = int'(result);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int res, rid, lat, held, dbits;
    int order[$];
    int results[$];
    int idle_cycles;
    int idx;
    int saw_done;
    int exp_order[4];

    reset   = 1'b1;
    req     = '0;
    operand = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check_output("reset_grant", int'(grant), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_result", int'(result), 0);
    check_output("reset_result_id", int'(result_id), 0);

    // Vector table: requester, operand, expected root, expected done cycle.
    vecs[0] = '{2, 0, 0, 3};
    vecs[1] = '{2, 1, 1, 4};
    vecs[2] = '{2, 4, 2, 5};
    vecs[3] = '{2, 255, 15, 18};
    vecs[4] = '{1, 100, 10, 13};
    vecs[5] = '{3, 15, 3, 6};
    vecs[6] = '{0, 16, 4, 7};
    vecs[7] = '{3, 224, 14, 17};
    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].id, vecs[v].op, res, rid, lat, held, dbits);
      check_output($sformatf("vec%0d_result", v), res, vecs[v].exp_res);
      check_output($sformatf("vec%0d_result_id", v), rid, vecs[v].id);
      check_output($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check_output($sformatf("vec%0d_done_bits", v), dbits, 1 << vecs[v].id);
      check_output($sformatf("vec%0d_result_held", v), held, vecs[v].exp_res);
    end

    // Exhaustive sweep on requester 0.
    for (int x = 0; x < 256; x++) begin
      apply_stimulus(0, x, res, rid, lat, held, dbits);
      check_output($sformatf("sweep%0d_result", x), res, ref_sqrt(x));
      check_output($sformatf("sweep%0d_latency", x), lat, ref_sqrt(x) + 3);
    end

    // Random requester/operand jobs.
    for (int t = 0; t < 60; t++) begin
      int id, op;
      id = int'($urandom_range(0, N - 1));
      op = int'($urandom_range(0, 255));
      apply_stimulus(id, op, res, rid, lat, held, dbits);
      check_output($sformatf("rand%0d_result", t), res, ref_sqrt(op));
      check_output($sformatf("rand%0d_result_id", t), rid, id);
      check_output($sformatf("rand%0d_latency", t), lat, ref_sqrt(op) + 3);
    end

    // All four requesting at once, each holding until its own done.
    do_reset();
    operand = {8'd49, 8'd36, 8'd25, 8'd16};
    req = 4'hF;
    order.delete();
    results.delete();
    idle_cycles = 0;
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      @(negedge clock);
      if (order.size() > 0 && !busy) idle_cycles++;
      if (done != '0) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (done[i]) idx = i;
        order.push_back(idx);
        results.push_back(int'(result));
        if (idx >= 0) req[idx] = 1'b0;
      end
    end
    req = '0;
    check_output("all4_jobs", order.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("all4_order%0d", k), (k < order.size()) ? order[k] : -1, k);
      check_output($sformatf("all4_result%0d", k), (k < results.size()) ? results[k] : -1, 4 + k);
    end
    check_output("all4_idle_cycles", idle_cycles, 3);

    // Two permanent requesters: fairness (or fixed priority when enabled).
    do_reset();
`ifdef SQRT_SCHED_FIXED_PRIORITY_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    operand[7:0]  = 8'd9;
    operand[15:8] = 8'd4;
    req = 4'b0011;
    order.delete();
    results.delete();
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      @(negedge clock);
      if (done != '0) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (done[i]) idx = i;
        order.push_back(idx);
        results.push_back(int'(result));
        if (order.size() == 4) req = '0;
      end
    end
    req = '0;
    check_output("rr_jobs", order.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("rr_order%0d", k), (k < order.size()) ? order[k] : -1, exp_order[k]);
      check_output($sformatf("rr_result%0d", k), (k < results.size()) ? results[k] : -1,
                   (exp_order[k] == 0) ? 3 : 2);
    end

    // Requester 3 drops its request and changes its operand after the grant.
    do_reset();
    operand[31:24] = 8'd100;
    req[3] = 1'b1;
    @(negedge clock);
    check_output("drop_grant", int'(grant), 8);
    req[3] = 1'b0;
    operand[31:24] = 8'd0;
    lat = -1;
    dbits = 0;
    res = -1;
    rid = -1;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clock);
      if (done != '0) begin
        lat   = c;
        dbits = int'(done);
        res   = int'(result);
        rid   = int'(result_id);
        break;
      end
    end
    check_output("drop_latency", lat, 13);
    check_output("drop_done_bits", dbits, 8);
    check_output("drop_result", res, 10);
    check_output("drop_result_id", rid, 3);

    // Reset in the middle of an iteration aborts without a done pulse.
    do_reset();
    apply_stimulus(1, 81, res, rid, lat, held, dbits);
    check_output("pre_abort_result", res, 9);
    operand[7:0] = 8'd200;
    req[0] = 1'b1;
    repeat (8) @(negedge clock);
    check_output("abort_busy_before", int'(busy), 1);
    check_output("abort_grant_before", int'(grant), 1);
    reset = 1'b1;
    #1;
    check_output("abort_grant", int'(grant), 0);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_done", int'(done), 0);
    check_output("abort_result", int'(result), 0);
    check_output("abort_result_id", int'(result_id), 0);
    req = '0;
    @(negedge clock);
    reset = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (done != '0) saw_done = 1;
    end
    check_output("abort_no_done", saw_done, 0);
    check_output("abort_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
